// File: rtl/u_control_mc.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing.
// Optional retired-instruction counter enabled by U_CONTROL_PERF_EN.
module u_control_mc #(
  parameter int OPC_W   = 6,
  parameter int ALUC_W  = 3,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [OPC_W-1:0]  OpCode,
  output logic              PC_En,
  output logic              IR_En,
  output logic              BR_En,
  output logic [ALUC_W-1:0] AluC,
  output logic              EnW,
  output logic              EnR,
  output logic              Mux1,
  output logic              Mux2,
  output logic              Mux3,
  output logic              Branch,
  output logic              trap,
  output logic [3:0]        state_o
`ifdef U_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0]  instr_cnt
`endif
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);

  localparam logic [ALUC_W-1:0] ALU_R   = ALUC_W'(3'b000);
  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b011);

  if (MEM_LAT < 1 || CNT_W < 1) begin : g_param_chk
    $error("u_control_mc: MEM_LAT and CNT_W must be >= 1");
  end

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opc_d = OpCode;
        if (OpCode == OP_R)
          state_d = S_EXEC_R;
        else if (OpCode == OP_ADDI)
          state_d = S_EXEC_I;
        else if (OpCode == OP_LW || OpCode == OP_SW)
          state_d = S_MEM_ADDR;
        else if (OpCode == OP_BEQ)
          state_d = S_BRANCH;
        else
          state_d = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: begin
        cnt_d   = '0;
        state_d = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (hold) begin
      state_d = state_q;
      opc_d   = opc_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef U_CONTROL_PERF_EN
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             retire;

  // Only exits from a final phase enter FETCH, so this is retirement.
  always_comb begin
    retire = (state_d == S_FETCH) && (state_q != S_FETCH);
    icnt_d = retire ? icnt_q + 1'b1 : icnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) icnt_q <= '0;
    else        icnt_q <= icnt_d;
  end

  assign instr_cnt = rst_n ? icnt_q : '0;
`endif

  logic              pc_r, ir_r, br_r, enw_r, enr_r;
  logic              m1_r, m2_r, m3_r, bra_r, trap_r;
  logic [ALUC_W-1:0] aluc_r;

  always_comb begin
    pc_r   = 1'b0;
    ir_r   = 1'b0;
    br_r   = 1'b0;
    enw_r  = 1'b0;
    enr_r  = 1'b0;
    m1_r   = 1'b0;
    m2_r   = 1'b0;
    m3_r   = 1'b0;
    bra_r  = 1'b0;
    trap_r = 1'b0;
    aluc_r = '0;
    unique case (state_q)
      S_FETCH: begin
        pc_r = 1'b1;
        ir_r = 1'b1;
      end
      S_EXEC_R: aluc_r = ALU_R;
      S_EXEC_I: begin
        aluc_r = ALU_ADD;
        m3_r   = 1'b1;
      end
      S_WB_ALU: begin
        br_r   = 1'b1;
        m1_r   = 1'b1;
        m2_r   = (opc_q == OP_R);
        m3_r   = (opc_q != OP_R);
        aluc_r = (opc_q == OP_R) ? ALU_R : ALU_ADD;
      end
      S_MEM_ADDR: begin
        aluc_r = ALU_ADD;
        m3_r   = 1'b1;
      end
      S_MEM_RD: begin
        enr_r  = 1'b1;
        aluc_r = ALU_ADD;
        m3_r   = 1'b1;
      end
      S_WB_MEM: br_r = 1'b1;
      S_MEM_WR: begin
        enw_r  = 1'b1;
        aluc_r = ALU_ADD;
        m3_r   = 1'b1;
      end
      S_BRANCH: begin
        aluc_r = ALU_SUB;
        bra_r  = 1'b1;
      end
      S_TRAP:   trap_r = 1'b1;
      default:  trap_r = 1'b0;
    endcase
  end

  // Reset forces everything low; hold suppresses state-changing strobes.
  always_comb begin
    PC_En   = rst_n & ~hold & pc_r;
    IR_En   = rst_n & ~hold & ir_r;
    BR_En   = rst_n & ~hold & br_r;
    EnW     = rst_n & ~hold & enw_r;
    EnR     = rst_n & enr_r;
    Mux1    = rst_n & m1_r;
    Mux2    = rst_n & m2_r;
    Mux3    = rst_n & m3_r;
    Branch  = rst_n & bra_r;
    trap    = rst_n & trap_r;
    AluC    = rst_n ? aluc_r : '0;
    state_o = rst_n ? state_q : 4'd0;
  end

endmodule

// File: tb/tb_u_control_mc.sv
// Directed vector bench for u_control_mc (MEM_LAT=3, CNT_W=4).
// Rows give per-cycle inputs and the outputs expected in that cycle.
module tb_u_control_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic [5:0] OpCode;
  logic       PC_En, IR_En, BR_En, EnW, EnR;
  logic       Mux1, Mux2, Mux3, Branch, trap;
  logic [2:0] AluC;
  logic [3:0] state_o;
`ifdef U_CONTROL_PERF_EN
  logic [3:0] instr_cnt;
`endif

  always #5 clk = ~clk;

  u_control_mc #(
    .OPC_W(6), .ALUC_W(3), .MEM_LAT(3), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .OpCode(OpCode),
    .PC_En(PC_En), .IR_En(IR_En), .BR_En(BR_En), .AluC(AluC),
    .EnW(EnW), .EnR(EnR), .Mux1(Mux1), .Mux2(Mux2), .Mux3(Mux3),
    .Branch(Branch), .trap(trap), .state_o(state_o)
`ifdef U_CONTROL_PERF_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  // {PC_En,IR_En,BR_En,AluC,EnW,EnR,Mux1,Mux2,Mux3,Branch,trap}
  localparam logic [12:0] O_NONE = 13'b0_0_0_000_0_0_0_0_0_0_0;
  localparam logic [12:0] O_FET  = 13'b1_1_0_000_0_0_0_0_0_0_0;
  localparam logic [12:0] O_EXI  = 13'b0_0_0_010_0_0_0_0_1_0_0;
  localparam logic [12:0] O_WBR  = 13'b0_0_1_000_0_0_1_1_0_0_0;
  localparam logic [12:0] O_WBI  = 13'b0_0_1_010_0_0_1_0_1_0_0;
  localparam logic [12:0] O_MRD  = 13'b0_0_0_010_0_1_0_0_1_0_0;
  localparam logic [12:0] O_WBM  = 13'b0_0_1_000_0_0_0_0_0_0_0;
  localparam logic [12:0] O_MWR  = 13'b0_0_0_010_1_0_0_0_1_0_0;
  localparam logic [12:0] O_BEQ  = 13'b0_0_0_011_0_0_0_0_0_1_0;
  localparam logic [12:0] O_TRP  = 13'b0_0_0_000_0_0_0_0_0_0_1;

  localparam logic [5:0] R = 6'b000000, AI = 6'b001000;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic        hld;
    logic [5:0]  opc;
    logic [3:0]  st;
    logic [12:0] outs;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic r, logic h, logic [5:0] o,
                              logic [3:0] s, logic [12:0] x);
    vec_t v;
    v.rst = r; v.hld = h; v.opc = o; v.st = s; v.outs = x;
    return v;
  endfunction

  function automatic logic [12:0] outs_now();
    return {PC_En, IR_En, BR_En, AluC, EnW, EnR,
            Mux1, Mux2, Mux3, Branch, trap};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic h, logic [5:0] o);
    rst_n = r; hold = h; OpCode = o;
    #1;
  endtask

  vec_t tbl[32];

  initial begin
    rst_n = 1'b0; hold = 1'b0; OpCode = '0;
    tbl[0]  = mk(0, 0, R,   4'd0,  O_NONE);
    tbl[1]  = mk(1, 0, R,   4'd0,  O_FET);
    tbl[2]  = mk(1, 0, R,   4'd1,  O_NONE);
    tbl[3]  = mk(1, 0, BAD, 4'd2,  O_NONE);
    tbl[4]  = mk(1, 0, BAD, 4'd4,  O_WBR);
    tbl[5]  = mk(1, 0, AI,  4'd0,  O_FET);
    tbl[6]  = mk(1, 0, AI,  4'd1,  O_NONE);
    tbl[7]  = mk(1, 0, AI,  4'd3,  O_EXI);
    tbl[8]  = mk(1, 0, AI,  4'd4,  O_WBI);
    tbl[9]  = mk(1, 0, LW,  4'd0,  O_FET);
    tbl[10] = mk(1, 0, LW,  4'd1,  O_NONE);
    tbl[11] = mk(1, 0, SW,  4'd5,  O_EXI);
    tbl[12] = mk(1, 0, SW,  4'd6,  O_MRD);
    tbl[13] = mk(1, 0, SW,  4'd6,  O_MRD);
    tbl[14] = mk(1, 0, SW,  4'd6,  O_MRD);
    tbl[15] = mk(1, 0, SW,  4'd7,  O_WBM);
    tbl[16] = mk(1, 0, SW,  4'd0,  O_FET);
    tbl[17] = mk(1, 0, SW,  4'd1,  O_NONE);
    tbl[18] = mk(1, 0, LW,  4'd5,  O_EXI);
    tbl[19] = mk(1, 0, LW,  4'd8,  O_MWR);
    tbl[20] = mk(1, 1, LW,  4'd8,  O_EXI);
    tbl[21] = mk(1, 1, LW,  4'd8,  O_EXI);
    tbl[22] = mk(1, 0, LW,  4'd8,  O_MWR);
    tbl[23] = mk(1, 0, LW,  4'd8,  O_MWR);
    tbl[24] = mk(1, 1, BQ,  4'd0,  O_NONE);
    tbl[25] = mk(1, 0, BQ,  4'd0,  O_FET);
    tbl[26] = mk(1, 0, BQ,  4'd1,  O_NONE);
    tbl[27] = mk(1, 0, BQ,  4'd9,  O_BEQ);
    tbl[28] = mk(1, 0, BAD, 4'd0,  O_FET);
    tbl[29] = mk(1, 0, BAD, 4'd1,  O_NONE);
    tbl[30] = mk(1, 0, R,   4'd15, O_TRP);
    tbl[31] = mk(1, 1, R,   4'd15, O_TRP);

    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].rst, tbl[i].hld, tbl[i].opc);
      chk($sformatf("vec%0d_state", i), 16'(state_o), 16'(tbl[i].st));
      chk($sformatf("vec%0d_outs", i), 16'(outs_now()), 16'(tbl[i].outs));
      @(negedge clk);
    end

    // TRAP absorbs every opcode for 20 cycles
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 6'(i * 7));
      chk("trap_hold", {12'd0, state_o}, 16'd15);
      chk("trap_flag", 16'(trap), 16'd1);
      @(negedge clk);
    end
    drive(0, 0, R);
    chk("trap_rst_comb", 16'(outs_now()), 16'(O_NONE));
    @(negedge clk);
    drive(1, 0, R);
    chk("trap_clear_state", 16'(state_o), 16'd0);
    chk("trap_clear_outs", 16'(outs_now()), 16'(O_FET));

    // reset in the middle of a SW aborts the write
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, SW);
    end
    chk("abort_in_mwr", 16'(state_o), 16'd8);
    drive(0, 0, SW);
    chk("abort_enw_low", 16'(EnW), 16'd0);
    @(negedge clk);
    drive(1, 0, R);
    chk("abort_fetch", 16'(state_o), 16'd0);
    chk("abort_outs", 16'(outs_now()), 16'(O_FET));

`ifdef U_CONTROL_PERF_EN
    @(negedge clk);
    drive(0, 0, AI);
    @(negedge clk);
    drive(1, 0, AI);
    chk("perf_reset", 16'(instr_cnt), 16'd0);
    for (int i = 0; i < 17 * 4; i++) begin
      @(negedge clk);
      drive(1, 0, AI);
    end
    chk("perf_wrap_state", 16'(state_o), 16'd0);
    chk("perf_wrap", 16'(instr_cnt), 16'd1);
    drive(0, 0, AI);
    @(negedge clk);
    drive(1, 0, AI);
    chk("perf_clear", 16'(instr_cnt), 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/u_control_mc.md
# u_control_mc

Multi-cycle, parametrised successor to the single-cycle MIPS control decoder. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath enables (PC, IR, register bank, data memory, muxes, ALU control) one phase per cycle, which lets the datapath share one ALU and one memory port. It adds configurable data-memory latency, a global hold, a sticky illegal-opcode trap and defined outputs in every state (no latched controls).

## Interface
- `OPC_W`, 6, opcode width.
- `ALUC_W`, 3, ALU control width; ALU codes are zero-extended to this width.
- `MEM_LAT`, 1, data-memory access cycles (≥1); EnR/EnW held this many cycles.
- `CNT_W`, 16, width of instruction counter (only with `U_CONTROL_PERF_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `hold`  in  1  freeze FSM and wait counter.
- `OpCode`  in  OPC_W  opcode from IR, sampled in DECODE.
- `PC_En`  out  1  PC update (PC+4).
- `IR_En`  out  1  instruction register load.
- `BR_En`  out  1  register-bank write.
- `AluC`  out  ALUC_W  ALU operation.
- `EnW`  out  1  data-memory write.
- `EnR`  out  1  data-memory read.
- `Mux1`  out  1  write-back source: 1 = ALU, 0 = memory.
- `Mux2`  out  1  destination: 1 = rd, 0 = rt.
- `Mux3`  out  1  ALU B source: 1 = immediate, 0 = register.
- `Branch`  out  1  branch-compare phase.
- `trap`  out  1  sticky illegal-opcode flag.
- `state_o`  out  4  current state encoding.
- `instr_cnt`  out  CNT_W  retired-instruction count (macro only).

## Operation
- States and encodings, with outputs. Any output not listed is 0.
  - FETCH = 0: IR_En=1, PC_En=1.
  - DECODE = 1: no outputs.
  - EXEC_R = 2: AluC=000.
  - EXEC_I = 3: AluC=010, Mux3=1.
  - WB_ALU = 4: BR_En=1, Mux1=1, Mux2 = 1 from EXEC_R or 0 from EXEC_I. AluC and Mux3 keep their EXEC values.
  - MEM_ADDR = 5: AluC=010, Mux3=1.
  - MEM_RD = 6: EnR=1, AluC=010, Mux3=1.
  - WB_MEM = 7: BR_En=1, Mux1=0, Mux2=0.
  - MEM_WR = 8: EnW=1, AluC=010, Mux3=1.
  - BRANCH = 9: AluC=011, Branch=1.
  - TRAP = 15: trap=1.
- DECODE transitions:
  - 000000 → EXEC_R.
  - 001000 → EXEC_I.
  - 100011 and 101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - Any other opcode → TRAP.
- MEM_ADDR goes to MEM_RD for LW and to MEM_WR for SW. The opcode is latched in DECODE, so OpCode changes after DECODE are ignored.
- MEM_RD and MEM_WR each stay MEM_LAT cycles, counted by a `$clog2(MEM_LAT+1)`-bit counter. The counter clears on entry and on exit.
- Exits:
  - MEM_RD → WB_MEM.
  - MEM_WR → FETCH.
  - WB_ALU, WB_MEM and BRANCH → FETCH.
- TRAP is absorbing until reset; all enables are 0 while in TRAP.
- `hold` = 1 freezes state, latched opcode and counter. While held:
  - PC_En, IR_En, BR_En and EnW are forced to 0.
  - EnR, AluC, the muxes and Branch keep their state values.

## Timing
- Reset (`rst_n` low at an edge) sets state = FETCH, counter = 0, trap = 0, instr_cnt = 0.
- While `rst_n` is low, all outputs are forced to 0 combinationally, including `state_o` = 0.
- The first cycle after reset release shows the FETCH outputs.
- Latency in cycles, with no hold:
  - R-type and ADDI: 4.
  - LW: 4 + MEM_LAT.
  - SW: 3 + MEM_LAT.
  - BEQ: 3.
- Reset asserted mid-instruction aborts it at the next edge. No partial write completes after that edge.
- `hold` asserted in the final cycle of a state delays the transition; the counter does not advance.
- Outputs are pure functions of the registered state (Moore), except for the `hold` and reset gating.

## Configuration
- `U_CONTROL_PERF_EN` defined:
  - Adds `instr_cnt`, which increments once per retired instruction.
  - Retirement is any transition into FETCH from WB_ALU, WB_MEM, MEM_WR or BRANCH.
  - The counter wraps modulo 2^CNT_W and does not count while in TRAP.
- `U_CONTROL_PERF_EN` undefined: the `instr_cnt` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then R-type 000000 → state_o sequence 0,1,2,4,0. BR_En=1, Mux1=1, Mux2=1 only in cycle 4.
- LW 100011 with MEM_LAT=3 → states 0,1,5,6,6,6,7,0. EnR high for exactly 3 cycles. WB_MEM shows Mux1=0, Mux2=0.
- SW 101011 with `hold` pulsed for 2 cycles in the 2nd MEM_WR cycle → EnW=0 during the hold. EnW is high for 3 non-held cycles in total, then FETCH.
- BEQ 000100 → Branch=1 and AluC=011 for one cycle, then FETCH; BR_En, EnW and EnR stay 0 throughout.
- Opcode 111111 → TRAP (state_o=15), trap=1 held for 20 cycles; `rst_n` low for 1 edge → FETCH, trap=0.
- PERF: CNT_W=4, run 17 ADDI instructions → instr_cnt=1 (wrapped). Reset → 0.
